mdu_unit: RTL and testbench
===========================

// Module: mdu_unit
// PURPOSE
//  E-stage multiply/divide unit with HI/LO registers. Consumes the one-hot decode strobes
//  (mult/multu/div/divu/mfhi/mflo/mthi/mtlo) carried down from ID with GPR[rs]/GPR[rt].
//  Runs fixed-latency ops while raising busy so the hazard unit can stall later MD instructions.
//  Drives the mfhi/mflo read value into the E-stage result mux.
// PARAMETERS
//  MULT_CYCLES  5   busy cycles for mult/multu (>=1)
//  DIV_CYCLES   10  busy cycles for div/divu (>=1)
// PORTS
//  clk      in   1   single clock; all state updates on its rising edge
//  reset    in   1   asynchronous, active-low reset
//  mult     in   1   decoded strobe: signed multiply
//  multu    in   1   decoded strobe: unsigned multiply
//  div      in   1   decoded strobe: signed divide
//  divu     in   1   decoded strobe: unsigned divide
//  mfhi     in   1   decoded strobe: read HI
//  mflo     in   1   decoded strobe: read LO
//  mthi     in   1   decoded strobe: write HI
//  mtlo     in   1   decoded strobe: write LO
//  a        in   32  operand A (GPR[rs], forwarded)
//  b        in   32  operand B (GPR[rt], forwarded)
//  req      in   1   exception/interrupt flush from CP0: suppresses this cycle's E instr
//  start    out  1   combinational: an op is accepted this cycle
//  busy     out  1   registered: op in flight
//  out      out  32  combinational: mfhi ? HI : mflo ? LO : 0
//  hi       out  32  current HI register
//  lo       out  32  current LO register
// BEHAVIOUR
//  - Reset (async, reset==0): HI=0, LO=0, busy=0, count=0, pending result=0. start and out
//    then follow the comb rules. Reset mid-op aborts it; nothing is committed.
//  - start = (mult|multu|div|divu) & ~req & ~busy.
//  - Cycle T with start=1: latch the result into pending {phi,plo} and load count with
//    MULT_CYCLES or DIV_CYCLES; busy=1 from T+1.
//  - While busy: count decrements each edge. At the edge where count==1: HI<=phi, LO<=plo,
//    busy<=0. So busy is high exactly N cycles (T+1..T+N); new HI/LO visible from T+N+1.
//  - mult: {HI,LO}=$signed(a)*$signed(b) (64-bit). multu: same, unsigned.
//  - div: LO=quotient truncated toward zero; HI=remainder with the sign of a.
//    0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0.
//  - divu: unsigned quotient/remainder.
//  - b==0 on div/divu: op still runs full DIV_CYCLES with busy; HI/LO are left unchanged.
//  - mthi/mtlo: at the edge, HI<=a / LO<=a when ~req & ~busy & ~start. They are ignored
//    while busy; the hazard unit guarantees this never happens.
//  - MD strobe while busy: ignored (no restart, no corruption). The hazard unit stalls
//    when busy|start and the E or D instr is an MD instr.
//  - req=1: blocks start and mt writes this cycle. An op already in flight completes and
//    commits normally (it was issued before the flushed instruction).
//  - out is independent of req/busy. mfhi/mflo while busy returns the old HI/LO; the
//    stall prevents that use.
//  - At most one strobe is high per cycle (guaranteed by the decoder). Behaviour with more
//    than one high is unspecified.
// TESTING
//  1 mult a=0xFFFFFFFE(-2) b=3 -> start=1 at T; busy T+1..T+5; at T+6 HI=0xFFFFFFFF,
//    LO=0xFFFFFFFA.
//  2 multu a=0xFFFFFFFF b=2 -> at T+6 HI=1, LO=0xFFFFFFFE.
//  3 div a=-7 b=2 -> busy 10 cycles; LO=0xFFFFFFFD, HI=0xFFFFFFFF.
//    divu a=7 b=2 -> LO=3, HI=1.
//    div 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0.
//  4 div a=5 b=0 with HI=0x11, LO=0x22 -> busy 10 cycles; afterwards HI=0x11, LO=0x22.
//  5 mthi a=0x1234 then mflo / mfhi -> out=LO, then out=0x1234.
//    mthi with req=1 -> HI unchanged. mult with req=1 -> start=0, busy stays 0.
//  6 reset low at T+3 of a div -> busy=0, HI=LO=0 immediately.
//    A second mult strobe during busy -> ignored; the first result commits at the
//    original cycle.

Source files
------------

// File: rtl/mdu_unit_if.sv
// Bundles the E-stage multiply/divide strobes, operands and results.
// The pipeline drives the master side; the MD unit sits on the slave side.
interface mdu_unit_if;
  logic        mult;
  logic        multu;
  logic        div;
  logic        divu;
  logic        mfhi;
  logic        mflo;
  logic        mthi;
  logic        mtlo;
  logic [31:0] a;
  logic [31:0] b;
  logic        req;
  logic        start;
  logic        busy;
  logic [31:0] out;
  logic [31:0] hi;
  logic [31:0] lo;

  modport master (
    output mult, multu, div, divu, mfhi, mflo, mthi, mtlo, a, b, req,
    input  start, busy, out, hi, lo
  );

  modport slave (
    input  mult, multu, div, divu, mfhi, mflo, mthi, mtlo, a, b, req,
    output start, busy, out, hi, lo
  );
endinterface

// File: rtl/mdu_unit.sv
// E-stage multiply/divide unit with HI/LO registers. The result is computed at issue
// and held back for a fixed latency so the hazard unit sees a realistic busy window.
module mdu_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic         clk,
  input  logic         reset,
  mdu_unit_if.slave    md
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW         = $clog2(MAX_CYCLES + 1);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t        state, state_next;
  logic [CW-1:0] count;
  logic [31:0]   hi_reg, lo_reg;
  logic [31:0]   phi, plo;
  logic          pend_ok;
  logic          start;
  logic          busy;
  logic          commit;
  logic          mt_ok;
  logic          md_op;
  logic          is_mult;

  logic [63:0]   prod_s, prod_u;
  logic [31:0]   a_mag, b_mag, divisor, q_mag, r_mag, quot, rem;
  logic [31:0]   res_hi, res_lo;

  assign busy    = (state == BUSY);
  assign md_op   = md.mult | md.multu | md.div | md.divu;
  assign is_mult = md.mult | md.multu;
  assign start   = md_op & ~md.req & ~busy;
  assign mt_ok   = ~md.req & ~busy & ~start;

  // Signed divide works on magnitudes so INT_MIN / -1 wraps cleanly and
  // divide-by-zero never reaches the divider.
  always_comb begin
    prod_s  = $signed({{32{md.a[31]}}, md.a}) * $signed({{32{md.b[31]}}, md.b});
    prod_u  = {32'd0, md.a} * {32'd0, md.b};
    a_mag   = (md.div & md.a[31]) ? -md.a : md.a;
    b_mag   = (md.div & md.b[31]) ? -md.b : md.b;
    divisor = (b_mag == 32'd0) ? 32'd1 : b_mag;
    q_mag   = a_mag / divisor;
    r_mag   = a_mag % divisor;
    quot    = (md.div & (md.a[31] ^ md.b[31])) ? -q_mag : q_mag;
    rem     = (md.div & md.a[31]) ? -r_mag : r_mag;
    res_hi  = rem;
    res_lo  = quot;
    if (md.mult) begin
      res_hi = prod_s[63:32];
      res_lo = prod_s[31:0];
    end else if (md.multu) begin
      res_hi = prod_u[63:32];
      res_lo = prod_u[31:0];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    commit     = 1'b0;
    case (state)
      IDLE: if (start) state_next = BUSY;
      BUSY: if (count == CW'(1)) begin
        state_next = IDLE;
        commit     = 1'b1;
      end
      default: state_next = IDLE;
    endcase
  end

  // The pending result is latched at issue; a divide by zero runs its full latency
  // but is marked so that HI/LO keep their old values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count   <= '0;
      phi     <= '0;
      plo     <= '0;
      pend_ok <= 1'b0;
    end else if (start) begin
      count   <= is_mult ? CW'(MULT_CYCLES) : CW'(DIV_CYCLES);
      phi     <= res_hi;
      plo     <= res_lo;
      pend_ok <= is_mult | (md.b != 32'd0);
    end else if (busy) begin
      count   <= count - CW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hi_reg <= '0;
      lo_reg <= '0;
    end else if (commit) begin
      if (pend_ok) begin
        hi_reg <= phi;
        lo_reg <= plo;
      end
    end else begin
      if (mt_ok & md.mthi) hi_reg <= md.a;
      if (mt_ok & md.mtlo) lo_reg <= md.a;
    end
  end

  assign md.start = start;
  assign md.busy  = busy;
  assign md.hi    = hi_reg;
  assign md.lo    = lo_reg;
  assign md.out   = md.mfhi ? hi_reg : (md.mflo ? lo_reg : 32'd0);

endmodule

// File: tb/tb_mdu_unit.sv
// Scoreboard bench for mdu_unit: each op pushes its expected HI/LO and busy length,
// and a monitor checks them when busy drops.
module tb_mdu_unit;

  localparam int MULT_CYCLES = 5;
  localparam int DIV_CYCLES  = 10;

  localparam logic [7:0] S_NONE  = 8'b0000_0000;
  localparam logic [7:0] S_MULT  = 8'b1000_0000;
  localparam logic [7:0] S_MULTU = 8'b0100_0000;
  localparam logic [7:0] S_DIV   = 8'b0010_0000;
  localparam logic [7:0] S_DIVU  = 8'b0001_0000;
  localparam logic [7:0] S_MFHI  = 8'b0000_1000;
  localparam logic [7:0] S_MFLO  = 8'b0000_0100;
  localparam logic [7:0] S_MTHI  = 8'b0000_0010;
  localparam logic [7:0] S_MTLO  = 8'b0000_0001;

  typedef struct {
    string       tag;
    logic [31:0] hi;
    logic [31:0] lo;
    int          cycles;
  } exp_t;

  logic clk;
  logic reset;
  mdu_unit_if md ();

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;

  mdu_unit #(.MULT_CYCLES(MULT_CYCLES), .DIV_CYCLES(DIV_CYCLES)) dut (
    .clk   (clk),
    .reset (reset),
    .md    (md)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [7:0] s, input logic [31:0] av, input logic [31:0] bv,
                       input logic rq);
    md.mult  = s[7];
    md.multu = s[6];
    md.div   = s[5];
    md.divu  = s[4];
    md.mfhi  = s[3];
    md.mflo  = s[2];
    md.mthi  = s[1];
    md.mtlo  = s[0];
    md.a     = av;
    md.b     = bv;
    md.req   = rq;
  endtask

  // Holds one strobe for exactly one cycle and checks start mid-cycle.
  task automatic apply_stimulus(input string name, input logic [7:0] s, input logic [31:0] av,
                                input logic [31:0] bv, input logic rq, input logic exp_start);
    @(posedge clk);
    #1 drive(s, av, bv, rq);
    @(negedge clk);
    check({name, ".start"}, {31'd0, md.start}, {31'd0, exp_start});
    @(posedge clk);
    #1 drive(S_NONE, 32'd0, 32'd0, 1'b0);
  endtask

  task automatic expect_op(input string tag, input logic [31:0] h, input logic [31:0] l,
                           input int cyc);
    exp_t e;
    e.tag    = tag;
    e.hi     = h;
    e.lo     = l;
    e.cycles = cyc;
    sb.push_back(e);
  endtask

  task automatic wait_done(input string name);
    int n = 0;
    while (sb.size() != 0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      checks++;
      failures++;
      $display("[TB] FAIL %s.timeout: %0d results still pending, expected 0", name, sb.size());
      sb.delete();
    end
  endtask

  // Monitor: counts busy cycles and checks HI/LO on every busy fall.
  initial begin
    int   busy_len  = 0;
    logic busy_prev = 1'b0;
    exp_t e;
    forever begin
      @(negedge clk);
      if (md.busy === 1'b1) begin
        busy_len++;
      end else if (busy_prev) begin
        if (sb.size() == 0) begin
          checks++;
          failures++;
          $display("[TB] FAIL unexpected_done: got busy fall, expected none");
        end else begin
          e = sb.pop_front();
          check({e.tag, ".hi"}, md.hi, e.hi);
          check({e.tag, ".lo"}, md.lo, e.lo);
          if (e.cycles >= 0) check({e.tag, ".busy_len"}, 32'(busy_len), 32'(e.cycles));
        end
        busy_len = 0;
      end
      busy_prev = (md.busy === 1'b1);
    end
  end

  task automatic check_output(input string name, input logic [7:0] s, input logic [31:0] exp);
    @(posedge clk);
    #1 drive(s, 32'hA5A5_A5A5, 32'h5A5A_5A5A, 1'b0);
    @(negedge clk);
    check(name, md.out, exp);
    @(posedge clk);
    #1 drive(S_NONE, 32'd0, 32'd0, 1'b0);
  endtask

  initial begin
    drive(S_NONE, 32'd0, 32'd0, 1'b0);
    reset = 1'b0;
    #12;
    check("reset.hi",    md.hi, 32'd0);
    check("reset.lo",    md.lo, 32'd0);
    check("reset.busy",  {31'd0, md.busy}, 32'd0);
    check("reset.out",   md.out, 32'd0);
    @(posedge clk);
    #1 reset = 1'b1;

    expect_op("mult", 32'hFFFF_FFFF, 32'hFFFF_FFFA, MULT_CYCLES);
    apply_stimulus("mult", S_MULT, 32'hFFFF_FFFE, 32'd3, 1'b0, 1'b1);
    wait_done("mult");

    expect_op("multu", 32'd1, 32'hFFFF_FFFE, MULT_CYCLES);
    apply_stimulus("multu", S_MULTU, 32'hFFFF_FFFF, 32'd2, 1'b0, 1'b1);
    wait_done("multu");

    expect_op("div_neg", 32'hFFFF_FFFF, 32'hFFFF_FFFD, DIV_CYCLES);
    apply_stimulus("div_neg", S_DIV, 32'hFFFF_FFF9, 32'd2, 1'b0, 1'b1);
    wait_done("div_neg");

    expect_op("divu", 32'd1, 32'd3, DIV_CYCLES);
    apply_stimulus("divu", S_DIVU, 32'd7, 32'd2, 1'b0, 1'b1);
    wait_done("divu");

    expect_op("div_ovf", 32'd0, 32'h8000_0000, DIV_CYCLES);
    apply_stimulus("div_ovf", S_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b1);
    wait_done("div_ovf");

    apply_stimulus("mthi11", S_MTHI, 32'h11, 32'd0, 1'b0, 1'b0);
    apply_stimulus("mtlo22", S_MTLO, 32'h22, 32'd0, 1'b0, 1'b0);
    expect_op("div_zero", 32'h11, 32'h22, DIV_CYCLES);
    apply_stimulus("div_zero", S_DIV, 32'd5, 32'd0, 1'b0, 1'b1);
    wait_done("div_zero");

    apply_stimulus("mthi1234", S_MTHI, 32'h1234, 32'd0, 1'b0, 1'b0);
    check_output("mflo.out", S_MFLO, 32'h22);
    check_output("mfhi.out", S_MFHI, 32'h1234);
    check_output("idle.out", S_NONE, 32'd0);

    apply_stimulus("mthi_req", S_MTHI, 32'hDEAD, 32'd0, 1'b1, 1'b0);
    @(negedge clk);
    check("mthi_req.hi", md.hi, 32'h1234);
    apply_stimulus("mult_req", S_MULT, 32'd3, 32'd4, 1'b1, 1'b0);
    @(negedge clk);
    check("mult_req.busy", {31'd0, md.busy}, 32'd0);

    expect_op("mult_ignore", 32'd0, 32'd12, MULT_CYCLES);
    apply_stimulus("mult_first", S_MULT, 32'd3, 32'd4, 1'b0, 1'b1);
    apply_stimulus("mult_second", S_MULT, 32'd5, 32'd5, 1'b0, 1'b0);
    wait_done("mult_ignore");

    // Abort: busy falls on reset, so the monitor sees cleared HI/LO.
    expect_op("div_abort", 32'd0, 32'd0, -1);
    apply_stimulus("div_abort", S_DIV, 32'd100, 32'd7, 1'b0, 1'b1);
    @(posedge clk);
    @(posedge clk);
    #1 reset = 1'b0;
    #1;
    check("abort.busy", {31'd0, md.busy}, 32'd0);
    check("abort.hi",   md.hi, 32'd0);
    check("abort.lo",   md.lo, 32'd0);
    @(posedge clk);
    #1 reset = 1'b1;
    wait_done("div_abort");
    repeat (12) @(negedge clk);
    check("post_abort.lo", md.lo, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
